// File: rtl/order_match.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | order_match : one-level bid/ask book with a single-trade matcher       |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module order_match (
  input  logic       clk,
  input  logic       reset,
  input  logic       order_valid,
  output logic       order_ready,
  input  logic       order_side,
  input  logic [7:0] order_price,
  input  logic [7:0] order_qty,
  output logic [7:0] buy_price,
  output logic [7:0] sell_price,
  output logic [7:0] buy_qty,
  output logic [7:0] sell_qty,
  output logic       match_signal,
  output logic [7:0] match_price,
  output logic [7:0] match_qty,
  output logic [15:0] match_count,
  output logic       reject
);

  localparam logic [7:0] NO_BID = 8'h00;
  localparam logic [7:0] NO_ASK = 8'hFF;

  typedef enum logic [0:0] {IDLE = 1'b0, EVAL = 1'b1} state_t;
  state_t r_state, w_next_state;

  logic       r_side;
  logic [7:0] r_price, r_qty;

  logic       w_illegal, w_cross, w_better;
  logic [7:0] w_rest_price, w_rest_qty, w_own_price, w_own_qty;
  logic [7:0] w_trade_qty, w_rest_left, w_rem;
  logic [8:0] w_sum;
  logic [7:0] w_own_price_n, w_own_qty_n, w_rest_price_n, w_rest_qty_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    order_ready  = 1'b0;
    case (r_state)
      IDLE: begin
        order_ready = 1'b1;
        if (order_valid) w_next_state = EVAL;
      end
      EVAL:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // "rest" is the opposite side the order may trade against; "own" is where a remainder lands
  always_comb begin
    w_illegal    = (r_qty == 8'd0) || (!r_side && r_price == NO_BID) || (r_side && r_price == NO_ASK);
    w_rest_price = r_side ? buy_price  : sell_price;
    w_rest_qty   = r_side ? buy_qty    : sell_qty;
    w_own_price  = r_side ? sell_price : buy_price;
    w_own_qty    = r_side ? sell_qty   : buy_qty;
    w_cross      = !w_illegal && (w_rest_qty != 8'd0) &&
                   (r_side ? (r_price <= w_rest_price) : (r_price >= w_rest_price));
    w_trade_qty  = 8'd0;
    if (w_cross) w_trade_qty = (r_qty < w_rest_qty) ? r_qty : w_rest_qty;
    w_rest_left  = w_rest_qty - w_trade_qty;
    w_rem        = r_qty - w_trade_qty;
    w_better     = r_side ? (r_price < w_own_price) : (r_price > w_own_price);
    w_sum        = {1'b0, w_own_qty} + {1'b0, w_rem};

    w_own_price_n = w_own_price;
    w_own_qty_n   = w_own_qty;
    if (w_rem != 8'd0) begin
      if (w_own_qty == 8'd0 || w_better) begin
        w_own_price_n = r_price;
        w_own_qty_n   = w_rem;
      end else if (r_price == w_own_price) begin
        w_own_qty_n = w_sum[8] ? 8'hFF : w_sum[7:0];
      end
    end

    w_rest_price_n = w_rest_price;
    w_rest_qty_n   = w_rest_left;
    if (w_rest_left == 8'd0) w_rest_price_n = r_side ? NO_BID : NO_ASK;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_side       <= 1'b0;
      r_price      <= 8'd0;
      r_qty        <= 8'd0;
      buy_price    <= NO_BID;
      buy_qty      <= 8'd0;
      sell_price   <= NO_ASK;
      sell_qty     <= 8'd0;
      match_signal <= 1'b0;
      match_price  <= 8'd0;
      match_qty    <= 8'd0;
      match_count  <= 16'd0;
      reject       <= 1'b0;
    end else begin
      match_signal <= 1'b0;
      reject       <= 1'b0;
      if (r_state == IDLE && order_valid) begin
        r_side  <= order_side;
        r_price <= order_price;
        r_qty   <= order_qty;
      end
      if (r_state == EVAL) begin
        if (w_illegal) begin
          reject <= 1'b1;
        end else begin
          if (r_side) begin
            buy_price  <= w_rest_price_n;
            buy_qty    <= w_rest_qty_n;
            sell_price <= w_own_price_n;
            sell_qty   <= w_own_qty_n;
          end else begin
            buy_price  <= w_own_price_n;
            buy_qty    <= w_own_qty_n;
            sell_price <= w_rest_price_n;
            sell_qty   <= w_rest_qty_n;
          end
          if (w_cross) begin
            match_signal <= 1'b1;
            match_price  <= w_rest_price;
            match_qty    <= w_trade_qty;
            match_count  <= match_count + 16'd1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
